// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a combinational instruction
// memory and fills the IF/ID pipeline register, with stall/flush/redirect/halt control.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 51,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_o,
    input  logic [31:0] inst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_inst_o,
    output logic        if_id_valid_o,
    output logic        misalign_o,
    output logic        fault_o,
    output logic        halted_o,
    output logic [31:0] fetch_count_o
);

    localparam int unsigned XLEN        = 32;
    localparam logic [XLEN-1:0] EBREAK  = 32'h0010_0073;
    localparam logic [XLEN-1:0] DEPTH_W = XLEN'(IMEM_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
        logic            valid;
    } if_id_t;

    localparam if_id_t BUBBLE = '{pc: '0, pc4: '0, inst: NOP_INST, valid: 1'b0};

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          if_id_q, if_id_d;
    logic            misalign_q, misalign_d;
    logic            fault_q, fault_d;
    logic            halted_q, halted_d;
    logic [XLEN-1:0] count_q, count_d;

    logic [XLEN-1:0] pc_plus4_c;
    logic [XLEN-1:0] word_idx_c;
    logic            range_ok_c;

    assign pc_plus4_c = pc_q + XLEN'(4);
    assign word_idx_c = pc_q >> 2;
    assign range_ok_c = (word_idx_c < DEPTH_W);

    // State register and all architectural/pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            if_id_q    <= BUBBLE;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_id_q    <= if_id_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
            halted_q   <= halted_d;
            count_q    <= count_d;
        end
    end

    // Next-state and next-register logic; redirect outranks everything outside BOOT
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_id_d    = if_id_q;
        misalign_d = 1'b0;
        fault_d    = fault_q;
        count_d    = count_q;

        if (state_q != ST_BOOT && redirect_i) begin
            pc_d       = {redirect_pc_i[31:2], 2'b00};
            if_id_d    = BUBBLE;
            fault_d    = 1'b0;
            misalign_d = |redirect_pc_i[1:0];
            state_d    = ST_RUN;
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    if_id_d = BUBBLE;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (stall_i) begin
                        if (flush_i) begin
                            if_id_d = BUBBLE;
                        end
                    end else if (flush_i) begin
                        if_id_d = BUBBLE;
                        pc_d    = pc_plus4_c;
                    end else if (!range_ok_c) begin
                        if_id_d = BUBBLE;
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        if_id_d = '{pc: pc_q, pc4: pc_plus4_c, inst: inst_i, valid: 1'b1};
                        count_d = count_q + XLEN'(1);
                        if (inst_i == EBREAK) begin
                            state_d = ST_HALT;
                        end else begin
                            pc_d = pc_plus4_c;
                        end
                    end
                end
                ST_HALT: begin
                    // EBREAK stays in IF/ID only until the first unstalled edge
                    if (!stall_i || flush_i) begin
                        if_id_d = BUBBLE;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end

        halted_d = (state_d == ST_HALT);
    end

    assign pc_o          = pc_q;
    assign if_id_pc_o    = if_id_q.pc;
    assign if_id_pc4_o   = if_id_q.pc4;
    assign if_id_inst_o  = if_id_q.inst;
    assign if_id_valid_o = if_id_q.valid;
    assign misalign_o    = misalign_q;
    assign fault_o       = fault_q;
    assign halted_o      = halted_q;
    assign fetch_count_o = count_q;

endmodule
